// File: rtl/rgb_fade_scheduler.sv
// rtl/rgb_fade_scheduler.sv - command-driven RGB duty fader with period-aligned PWM outputs
module rgb_fade_scheduler #(
  parameter int PWM_W  = 8,
  parameter int STEP_W = 20,
  parameter int HOLD_W = 24
) (
  input  logic              hw_clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [PWM_W-1:0]  cmd_red,
  input  logic [PWM_W-1:0]  cmd_green,
  input  logic [PWM_W-1:0]  cmd_blue,
  input  logic [STEP_W-1:0] cmd_step_div,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic              abort,
  output logic              pwm_red,
  output logic              pwm_green,
  output logic              pwm_blue,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_FADE, S_HOLD} state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [PWM_W-1:0]    r_pwm_cnt;
  logic [PWM_W-1:0]    r_work_red, r_work_green, r_work_blue;
  logic [PWM_W-1:0]    r_shadow_red, r_shadow_green, r_shadow_blue;
  logic [PWM_W-1:0]    r_tgt_red, r_tgt_green, r_tgt_blue;
  logic [STEP_W-1:0]   r_step_div;
  logic [STEP_W-1:0]   r_step_cnt;
  logic [HOLD_W-1:0]   r_hold;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_pwm_red, r_pwm_green, r_pwm_blue;
  logic                r_done;

  logic                w_accept;
  logic                w_all_eq;
  logic                w_step_hit;
  logic                w_step_fire;
  logic                w_hold_end;
  logic                w_nxt_eq;
  logic [PWM_W-1:0]    w_nxt_red, w_nxt_green, w_nxt_blue;

  // One LSB toward the target; never overshoots, so no saturation logic is needed.
  function automatic logic [PWM_W-1:0] f_step(input logic [PWM_W-1:0] cur,
                                              input logic [PWM_W-1:0] tgt);
    if (cur < tgt)      f_step = cur + PWM_W'(1);
    else if (cur > tgt) f_step = cur - PWM_W'(1);
    else                f_step = cur;
  endfunction

  assign cmd_ready   = (r_state == S_IDLE) && !abort;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign pwm_red     = r_pwm_red;
  assign pwm_green   = r_pwm_green;
  assign pwm_blue    = r_pwm_blue;

  assign w_accept    = cmd_valid && cmd_ready;
  assign w_all_eq    = (r_work_red == r_tgt_red) && (r_work_green == r_tgt_green) &&
                       (r_work_blue == r_tgt_blue);
  assign w_step_hit  = (r_step_cnt == (r_step_div - STEP_W'(1)));
  assign w_nxt_red   = f_step(r_work_red,   r_tgt_red);
  assign w_nxt_green = f_step(r_work_green, r_tgt_green);
  assign w_nxt_blue  = f_step(r_work_blue,  r_tgt_blue);
  assign w_nxt_eq    = (w_nxt_red == r_tgt_red) && (w_nxt_green == r_tgt_green) &&
                       (w_nxt_blue == r_tgt_blue);
  assign w_step_fire = (r_state == S_FADE) && !w_all_eq && w_step_hit;
  assign w_hold_end  = (r_state == S_HOLD) && (r_hold_cnt == r_hold);

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) w_next_state = S_FADE;
        S_FADE: if (w_all_eq || (w_step_fire && w_nxt_eq)) w_next_state = S_HOLD;
        S_HOLD: if (w_hold_end) w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt      <= '0;
      r_work_red     <= '0;
      r_work_green   <= '0;
      r_work_blue    <= '0;
      r_shadow_red   <= '0;
      r_shadow_green <= '0;
      r_shadow_blue  <= '0;
      r_tgt_red      <= '0;
      r_tgt_green    <= '0;
      r_tgt_blue     <= '0;
      r_step_div     <= '0;
      r_step_cnt     <= '0;
      r_hold         <= '0;
      r_hold_cnt     <= '0;
      r_pwm_red      <= 1'b0;
      r_pwm_green    <= 1'b0;
      r_pwm_blue     <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      r_done    <= 1'b0;
      if (abort) begin
        r_work_red     <= '0;
        r_work_green   <= '0;
        r_work_blue    <= '0;
        r_shadow_red   <= '0;
        r_shadow_green <= '0;
        r_shadow_blue  <= '0;
        r_pwm_red      <= 1'b0;
        r_pwm_green    <= 1'b0;
        r_pwm_blue     <= 1'b0;
        r_step_cnt     <= '0;
        r_hold_cnt     <= '0;
      end else begin
        r_pwm_red   <= (r_pwm_cnt < r_shadow_red);
        r_pwm_green <= (r_pwm_cnt < r_shadow_green);
        r_pwm_blue  <= (r_pwm_cnt < r_shadow_blue);
        // Shadow reload at the end of a period keeps each PWM period glitch-free.
        if (r_pwm_cnt == '1) begin
          r_shadow_red   <= r_work_red;
          r_shadow_green <= r_work_green;
          r_shadow_blue  <= r_work_blue;
        end
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_tgt_red   <= cmd_red;
              r_tgt_green <= cmd_green;
              r_tgt_blue  <= cmd_blue;
              r_step_div  <= (cmd_step_div == '0) ? STEP_W'(1) : cmd_step_div;
              r_hold      <= cmd_hold;
              r_step_cnt  <= '0;
            end
          end
          S_FADE: begin
            r_hold_cnt <= '0;
            if (!w_all_eq) begin
              if (w_step_hit) begin
                r_step_cnt   <= '0;
                r_work_red   <= w_nxt_red;
                r_work_green <= w_nxt_green;
                r_work_blue  <= w_nxt_blue;
              end else begin
                r_step_cnt <= r_step_cnt + STEP_W'(1);
              end
            end
          end
          S_HOLD: begin
            if (w_hold_end) r_done <= 1'b1;
            else            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule
